// File: rtl/pll_sup_pkg.sv
// Shared types and constants for the PLL lock supervisor.
package pll_sup_pkg;

    // Supervisor sequencing states.
    typedef enum logic [2:0] {
        ST_RST_PLL   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAULT     = 3'd4
    } pll_state_e;

    // Default sequencing parameters (12 MHz reference clock).
    localparam int DEF_RST_CYCLES    = 16;
    localparam int DEF_LOCK_TIMEOUT  = 4096;
    localparam int DEF_STABLE_CYCLES = 1024;
    localparam int DEF_DROP_FILTER   = 2;
    localparam int DEF_MAX_RETRIES   = 3;
    localparam int DEF_TMR_W         = 16;

    // Status counter widths.
    localparam int RETRY_W = 4;
    localparam int LOSS_W  = 8;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [LOSS_W-1:0] loss_sat_inc(input logic [LOSS_W-1:0] v);
        if (v == '1) begin
            return v;
        end
        return v + LOSS_W'(1);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for slow or level signals crossing into the clk domain.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // First flop may go metastable; second flop gives it a full cycle to settle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_supervisor.sv
// Sequences the PLL reset, qualifies lock, and gates the downstream system reset.
// Runs entirely on the reference clock so it never depends on the clock it supervises.
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int RST_CYCLES    = DEF_RST_CYCLES,
    parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int DROP_FILTER   = DEF_DROP_FILTER,
    parameter int MAX_RETRIES   = DEF_MAX_RETRIES,
    parameter int TMR_W         = DEF_TMR_W
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               PLL_LOCK,
    input  logic               RETRY_REQ,
    output logic               PLL_RESETB,
    output logic               SYS_RESETN,
    output logic               READY,
    output logic               FAULT,
    output logic [RETRY_W-1:0] RETRY_COUNT,
    output logic [LOSS_W-1:0]  LOSS_COUNT
);

    localparam logic [TMR_W-1:0]   RST_LAST     = TMR_W'(RST_CYCLES - 1);
    localparam logic [TMR_W-1:0]   TIMEOUT_LAST = TMR_W'(LOCK_TIMEOUT - 1);
    localparam logic [TMR_W-1:0]   STABLE_LAST  = TMR_W'(STABLE_CYCLES - 1);
    localparam logic [TMR_W-1:0]   DROP_LAST    = TMR_W'(DROP_FILTER - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRIES);

    pll_state_e         state_q;
    logic [TMR_W-1:0]   timer_q;
    logic [TMR_W-1:0]   drop_q;
    logic               pll_resetb_q;
    logic               sys_resetn_q;
    logic               ready_q;
    logic               fault_q;
    logic [RETRY_W-1:0] retry_q;
    logic [LOSS_W-1:0]  loss_q;

    logic               lock_s;
    logic [RETRY_W-1:0] retry_inc;

    sync_2ff #(
        .WIDTH(1)
    ) u_lock_sync (
        .clk  (CLK),
        .rst_n(RESET),
        .d_i  (PLL_LOCK),
        .q_o  (lock_s)
    );

    assign retry_inc = retry_q + RETRY_W'(1);

    // Sequencing FSM; every output flop changes on the same edge as its state transition.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q      <= ST_RST_PLL;
            timer_q      <= '0;
            drop_q       <= '0;
            pll_resetb_q <= 1'b0;
            sys_resetn_q <= 1'b0;
            ready_q      <= 1'b0;
            fault_q      <= 1'b0;
            retry_q      <= '0;
            loss_q       <= '0;
        end else begin
            case (state_q)
                ST_RST_PLL: begin
                    if (timer_q == RST_LAST) begin
                        state_q      <= ST_WAIT_LOCK;
                        timer_q      <= '0;
                        pll_resetb_q <= 1'b1;
                    end else begin
                        timer_q <= timer_q + TMR_W'(1);
                    end
                end
                ST_WAIT_LOCK: begin
                    if (lock_s) begin
                        state_q <= ST_STABLE;
                        timer_q <= '0;
                    end else if (timer_q == TIMEOUT_LAST) begin
                        timer_q      <= '0;
                        retry_q      <= retry_inc;
                        pll_resetb_q <= 1'b0;
                        if (retry_inc == RETRY_LIMIT) begin
                            state_q <= ST_FAULT;
                            fault_q <= 1'b1;
                        end else begin
                            state_q <= ST_RST_PLL;
                        end
                    end else begin
                        timer_q <= timer_q + TMR_W'(1);
                    end
                end
                ST_STABLE: begin
                    if (!lock_s) begin
                        state_q <= ST_WAIT_LOCK;
                        timer_q <= '0;
                    end else if (timer_q == STABLE_LAST) begin
                        state_q      <= ST_RUN;
                        timer_q      <= '0;
                        drop_q       <= '0;
                        sys_resetn_q <= 1'b1;
                        ready_q      <= 1'b1;
                        retry_q      <= '0;
                    end else begin
                        timer_q <= timer_q + TMR_W'(1);
                    end
                end
                ST_RUN: begin
                    if (lock_s) begin
                        drop_q <= '0;
                    end else if (drop_q == DROP_LAST) begin
                        state_q      <= ST_RST_PLL;
                        timer_q      <= '0;
                        drop_q       <= '0;
                        pll_resetb_q <= 1'b0;
                        sys_resetn_q <= 1'b0;
                        ready_q      <= 1'b0;
                        retry_q      <= '0;
                        loss_q       <= loss_sat_inc(loss_q);
                    end else begin
                        drop_q <= drop_q + TMR_W'(1);
                    end
                end
                ST_FAULT: begin
                    if (RETRY_REQ) begin
                        state_q <= ST_RST_PLL;
                        timer_q <= '0;
                        fault_q <= 1'b0;
                        retry_q <= '0;
                    end
                end
                default: begin
                    state_q      <= ST_RST_PLL;
                    timer_q      <= '0;
                    drop_q       <= '0;
                    pll_resetb_q <= 1'b0;
                    sys_resetn_q <= 1'b0;
                    ready_q      <= 1'b0;
                    fault_q      <= 1'b0;
                end
            endcase
        end
    end

    assign PLL_RESETB  = pll_resetb_q;
    assign SYS_RESETN  = sys_resetn_q;
    assign READY       = ready_q;
    assign FAULT       = fault_q;
    assign RETRY_COUNT = retry_q;
    assign LOSS_COUNT  = loss_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for the PLL lock supervisor using small sequencing parameters.
module tb_pll_lock_supervisor;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       PLL_LOCK;
    logic       RETRY_REQ;
    logic       PLL_RESETB;
    logic       SYS_RESETN;
    logic       READY;
    logic       FAULT;
    logic [3:0] RETRY_COUNT;
    logic [7:0] LOSS_COUNT;

    int checks = 0;
    int passed = 0;

    pll_lock_supervisor #(
        .RST_CYCLES   (4),
        .LOCK_TIMEOUT (20),
        .STABLE_CYCLES(8),
        .DROP_FILTER  (2),
        .MAX_RETRIES  (3),
        .TMR_W        (8)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .PLL_LOCK   (PLL_LOCK),
        .RETRY_REQ  (RETRY_REQ),
        .PLL_RESETB (PLL_RESETB),
        .SYS_RESETN (SYS_RESETN),
        .READY      (READY),
        .FAULT      (FAULT),
        .RETRY_COUNT(RETRY_COUNT),
        .LOSS_COUNT (LOSS_COUNT)
    );

    // 10-unit reference clock.
    always #5 CLK = ~CLK;

    // Advance one clock and settle just past the edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Hold reset for two cycles, then release; the next edge is edge 1.
    task automatic apply_reset(input logic lock);
        RESET     = 1'b0;
        PLL_LOCK  = lock;
        RETRY_REQ = 1'b0;
        tick();
        tick();
        RESET = 1'b1;
    endtask

    // Outputs must take reset values without any clock edge.
    task automatic test_reset();
        RESET     = 1'b0;
        PLL_LOCK  = 1'b0;
        RETRY_REQ = 1'b0;
        #2;
        checks++;
        if ({PLL_RESETB, SYS_RESETN, READY, FAULT} !== 4'b0000)
            $display("[TB] FAIL reset_flags: got %b want 0000", {PLL_RESETB, SYS_RESETN, READY, FAULT});
        else passed++;
        checks++;
        if ({RETRY_COUNT, LOSS_COUNT} !== 12'h000)
            $display("[TB] FAIL reset_counts: got %h want 000", {RETRY_COUNT, LOSS_COUNT});
        else passed++;
    endtask

    // Normal bring-up: 4-cycle PLL reset, lock 5 cycles later, RUN 2+8 cycles after lock is sampled.
    task automatic test_lock_up();
        apply_reset(1'b0);
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i <= 3) begin
                checks++;
                if (PLL_RESETB !== 1'b0) $display("[TB] FAIL up_rstb_low_%0d: got %b want 0", i, PLL_RESETB);
                else passed++;
            end
            if (i == 4) begin
                checks++;
                if (PLL_RESETB !== 1'b1) $display("[TB] FAIL up_rstb_rise: got %b want 1", PLL_RESETB);
                else passed++;
            end
            if (i == 9) PLL_LOCK = 1'b1;
            if (i == 19) begin
                checks++;
                if ({SYS_RESETN, READY} !== 2'b00) $display("[TB] FAIL up_early_run: got %b want 00", {SYS_RESETN, READY});
                else passed++;
            end
            if (i == 20) begin
                checks++;
                if ({SYS_RESETN, READY, PLL_RESETB, FAULT, RETRY_COUNT} !== 8'b1110_0000)
                    $display("[TB] FAIL up_run: got %b want 11100000", {SYS_RESETN, READY, PLL_RESETB, FAULT, RETRY_COUNT});
                else passed++;
            end
        end
    endtask

    // No lock ever: three timeouts lead to FAULT, RETRY_REQ leaves it.
    task automatic test_timeout_fault();
        apply_reset(1'b0);
        for (int i = 1; i <= 85; i++) begin
            tick();
            if (i == 9)  RETRY_REQ = 1'b1;
            if (i == 10) RETRY_REQ = 1'b0;
            if (i == 23) begin
                checks++;
                if ({PLL_RESETB, RETRY_COUNT} !== 5'b1_0000) $display("[TB] FAIL to_wait1: got %b want 10000", {PLL_RESETB, RETRY_COUNT});
                else passed++;
            end
            if (i == 24) begin
                checks++;
                if ({PLL_RESETB, RETRY_COUNT} !== 5'b0_0001) $display("[TB] FAIL to_retry1: got %b want 00001", {PLL_RESETB, RETRY_COUNT});
                else passed++;
            end
            if (i == 28) begin
                checks++;
                if (PLL_RESETB !== 1'b1) $display("[TB] FAIL to_rerise1: got %b want 1", PLL_RESETB);
                else passed++;
            end
            if (i == 48) begin
                checks++;
                if ({PLL_RESETB, RETRY_COUNT} !== 5'b0_0010) $display("[TB] FAIL to_retry2: got %b want 00010", {PLL_RESETB, RETRY_COUNT});
                else passed++;
            end
            if (i == 71) begin
                checks++;
                if ({FAULT, PLL_RESETB, RETRY_COUNT} !== 6'b01_0010) $display("[TB] FAIL to_prefault: got %b want 010010", {FAULT, PLL_RESETB, RETRY_COUNT});
                else passed++;
            end
            if (i == 72) begin
                checks++;
                if ({FAULT, PLL_RESETB, RETRY_COUNT} !== 6'b10_0011) $display("[TB] FAIL to_fault: got %b want 100011", {FAULT, PLL_RESETB, RETRY_COUNT});
                else passed++;
            end
            if (i == 80) begin
                checks++;
                if ({FAULT, PLL_RESETB, SYS_RESETN} !== 3'b100) $display("[TB] FAIL to_fault_hold: got %b want 100", {FAULT, PLL_RESETB, SYS_RESETN});
                else passed++;
                RETRY_REQ = 1'b1;
            end
            if (i == 81) begin
                RETRY_REQ = 1'b0;
                checks++;
                if ({FAULT, PLL_RESETB, RETRY_COUNT} !== 6'b00_0000) $display("[TB] FAIL to_retry_req: got %b want 000000", {FAULT, PLL_RESETB, RETRY_COUNT});
                else passed++;
            end
            if (i == 84) begin
                checks++;
                if (PLL_RESETB !== 1'b0) $display("[TB] FAIL to_new_rst: got %b want 0", PLL_RESETB);
                else passed++;
            end
            if (i == 85) begin
                checks++;
                if (PLL_RESETB !== 1'b1) $display("[TB] FAIL to_new_wait: got %b want 1", PLL_RESETB);
                else passed++;
            end
        end
    endtask

    // RUN ignores a 1-cycle dropout; a 3-cycle dropout counts as loss and re-sequences.
    task automatic test_glitch();
        apply_reset(1'b1);
        for (int i = 1; i <= 33; i++) begin
            tick();
            if (i == 12) begin
                checks++;
                if (READY !== 1'b0) $display("[TB] FAIL gl_pre_run: got %b want 0", READY);
                else passed++;
            end
            if (i == 13) begin
                checks++;
                if ({READY, SYS_RESETN} !== 2'b11) $display("[TB] FAIL gl_run: got %b want 11", {READY, SYS_RESETN});
                else passed++;
            end
            if (i == 15) PLL_LOCK = 1'b0;
            if (i == 16) PLL_LOCK = 1'b1;
            if (i == 20 || i == 22) begin
                checks++;
                if ({READY, SYS_RESETN, LOSS_COUNT} !== 10'b11_0000_0000)
                    $display("[TB] FAIL gl_short_%0d: got %b want 1100000000", i, {READY, SYS_RESETN, LOSS_COUNT});
                else passed++;
            end
            if (i == 25) PLL_LOCK = 1'b0;
            if (i == 28) begin
                PLL_LOCK = 1'b1;
                checks++;
                if ({READY, LOSS_COUNT} !== 9'b1_0000_0000) $display("[TB] FAIL gl_pre_loss: got %b want 100000000", {READY, LOSS_COUNT});
                else passed++;
            end
            if (i == 29) begin
                checks++;
                if ({READY, SYS_RESETN, PLL_RESETB, LOSS_COUNT} !== 11'b000_0000_0001)
                    $display("[TB] FAIL gl_loss: got %b want 00000000001", {READY, SYS_RESETN, PLL_RESETB, LOSS_COUNT});
                else passed++;
            end
            if (i == 32) begin
                checks++;
                if (PLL_RESETB !== 1'b0) $display("[TB] FAIL gl_reseq_low: got %b want 0", PLL_RESETB);
                else passed++;
            end
            if (i == 33) begin
                checks++;
                if (PLL_RESETB !== 1'b1) $display("[TB] FAIL gl_reseq_rise: got %b want 1", PLL_RESETB);
                else passed++;
            end
        end
    endtask

    // Lock dropout during qualification restarts the full 8-cycle stability window.
    task automatic test_stable_drop();
        apply_reset(1'b0);
        for (int i = 1; i <= 22; i++) begin
            tick();
            if (i == 4)  PLL_LOCK = 1'b1;
            if (i == 10) PLL_LOCK = 1'b0;
            if (i == 11) PLL_LOCK = 1'b1;
            if (i == 15 || i == 21) begin
                checks++;
                if ({SYS_RESETN, READY} !== 2'b00) $display("[TB] FAIL st_requal_%0d: got %b want 00", i, {SYS_RESETN, READY});
                else passed++;
            end
            if (i == 22) begin
                checks++;
                if ({SYS_RESETN, READY, RETRY_COUNT} !== 6'b11_0000) $display("[TB] FAIL st_run: got %b want 110000", {SYS_RESETN, READY, RETRY_COUNT});
                else passed++;
            end
        end
    endtask

    // Lock seen on the very cycle the wait expires: lock wins, no retry counted.
    task automatic test_lock_at_timeout();
        apply_reset(1'b0);
        for (int i = 1; i <= 32; i++) begin
            tick();
            if (i == 21) PLL_LOCK = 1'b1;
            if (i == 24) begin
                checks++;
                if ({PLL_RESETB, RETRY_COUNT} !== 5'b1_0000) $display("[TB] FAIL lt_no_retry: got %b want 10000", {PLL_RESETB, RETRY_COUNT});
                else passed++;
            end
            if (i == 31) begin
                checks++;
                if (READY !== 1'b0) $display("[TB] FAIL lt_pre_run: got %b want 0", READY);
                else passed++;
            end
            if (i == 32) begin
                checks++;
                if ({READY, RETRY_COUNT} !== 5'b1_0000) $display("[TB] FAIL lt_run: got %b want 10000", {READY, RETRY_COUNT});
                else passed++;
            end
        end
    endtask

    // Reset asserted mid-cycle in WAIT_LOCK and in RUN clears everything without a clock edge.
    task automatic test_async_reset();
        apply_reset(1'b0);
        for (int i = 1; i <= 8; i++) tick();
        checks++;
        if (PLL_RESETB !== 1'b1) $display("[TB] FAIL ar_wait_pre: got %b want 1", PLL_RESETB);
        else passed++;
        #3 RESET = 1'b0;
        #1;
        checks++;
        if ({PLL_RESETB, SYS_RESETN, READY, FAULT, RETRY_COUNT, LOSS_COUNT} !== 16'h0000)
            $display("[TB] FAIL ar_wait: got %h want 0000", {PLL_RESETB, SYS_RESETN, READY, FAULT, RETRY_COUNT, LOSS_COUNT});
        else passed++;

        apply_reset(1'b1);
        for (int i = 1; i <= 32; i++) begin
            tick();
            if (i == 15) PLL_LOCK = 1'b0;
            if (i == 17) PLL_LOCK = 1'b1;
            if (i == 19) begin
                checks++;
                if ({READY, LOSS_COUNT} !== 9'b0_0000_0001) $display("[TB] FAIL ar_loss2: got %b want 000000001", {READY, LOSS_COUNT});
                else passed++;
            end
        end
        checks++;
        if ({READY, SYS_RESETN, LOSS_COUNT} !== 10'b11_0000_0001) $display("[TB] FAIL ar_run_pre: got %b want 1100000001", {READY, SYS_RESETN, LOSS_COUNT});
        else passed++;
        #3 RESET = 1'b0;
        #1;
        checks++;
        if ({PLL_RESETB, SYS_RESETN, READY, FAULT, RETRY_COUNT, LOSS_COUNT} !== 16'h0000)
            $display("[TB] FAIL ar_run: got %h want 0000", {PLL_RESETB, SYS_RESETN, READY, FAULT, RETRY_COUNT, LOSS_COUNT});
        else passed++;
    endtask

    // 256 loss events: the loss counter must stick at 255.
    task automatic test_loss_saturate();
        logic ok;
        ok = 1'b1;
        apply_reset(1'b1);
        for (int n = 0; n < 256 && ok; n++) begin
            for (int c = 0; c < 40; c++) begin
                if (READY === 1'b1) break;
                tick();
            end
            checks++;
            if (READY !== 1'b1) begin
                $display("[TB] FAIL sat_wait_run_%0d: got %b want 1", n, READY);
                ok = 1'b0;
            end else passed++;
            if (ok) begin
                PLL_LOCK = 1'b0;
                tick();
                tick();
                PLL_LOCK = 1'b1;
                for (int c = 0; c < 10; c++) begin
                    if (READY === 1'b0) break;
                    tick();
                end
                checks++;
                if (READY !== 1'b0) begin
                    $display("[TB] FAIL sat_wait_loss_%0d: got %b want 0", n, READY);
                    ok = 1'b0;
                end else passed++;
            end
            if (ok && n == 254) begin
                checks++;
                if (LOSS_COUNT !== 8'd255) $display("[TB] FAIL sat_255: got %0d want 255", LOSS_COUNT);
                else passed++;
            end
        end
        checks++;
        if (LOSS_COUNT !== 8'd255) $display("[TB] FAIL sat_256: got %0d want 255", LOSS_COUNT);
        else passed++;
    endtask

    // Run every scenario in order, then report.
    initial begin
        test_reset();
        test_lock_up();
        test_timeout_fault();
        test_glitch();
        test_stable_drop();
        test_lock_at_timeout();
        test_async_reset();
        test_loss_saturate();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
